// File: rtl/cas_fsk_player.sv
`default_nettype none
// ============================================================================
//  Module      : cas_fsk_player
//  Description : Cassette playback engine. Fetches raw CAS bytes from SDRAM
//                one byte ahead of the emitter and plays them LSB-first as
//                FSK square waves (one cycle per bit, HALF0 / HALF1 clocks
//                per half-cycle for a 0 / 1 bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module cas_fsk_player #(
  parameter int HALF0  = 23864,
  parameter int HALF1  = 11932,
  parameter int RD_LAT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play_tgl,
  input  logic        rewind,
  input  logic        motor,
  input  logic [15:0] tape_len,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic        cas_out,
  output logic        playing,
  output logic        at_end,
  output logic [15:0] tape_pos
);

  localparam logic [15:0] C_H0_LAST = 16'(HALF0 - 1);
  localparam logic [15:0] C_H1_LAST = 16'(HALF1 - 1);
  localparam logic [3:0]  C_LAT     = 4'(RD_LAT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_t;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  // Fetch side
  logic [15:0] r_len;
  logic [15:0] r_faddr;
  logic [3:0]  r_lat;
  logic [7:0]  r_hold;
  logic        r_hold_valid;

  // Emitter side
  logic [7:0]  r_shift;
  logic [3:0]  r_bcnt;
  logic [15:0] r_cnt;
  logic        r_phase;
  logic        r_cas;
  logic        r_playing;
  logic        r_at_end;
  logic [15:0] r_pos;

  logic        w_issue;
  logic        w_capture;
  logic        w_active;
  logic        w_half_last;
  logic        w_bit_done;
  logic        w_byte_done;
  logic [15:0] w_pos_inc;
  logic        w_end;
  logic        w_load;

  assign w_active    = r_playing & motor;
  assign w_half_last = (r_cnt == (r_shift[0] ? C_H1_LAST : C_H0_LAST));
  assign w_bit_done  = w_active && (r_bcnt != 4'd0) && r_phase && w_half_last;
  assign w_byte_done = w_bit_done && (r_bcnt == 4'd1);
  assign w_pos_inc   = r_pos + 16'd1;
  assign w_end       = w_byte_done && (w_pos_inc == r_len);
  // Hold moves into the shifter either when the shifter is idle, or back to
  // back with the end of the previous byte so bytes follow with no gap.
  assign w_load      = w_active && r_hold_valid &&
                       ((r_bcnt == 4'd0) || (w_byte_done && !w_end));

  // Fetch FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Fetch FSM next state: one read outstanding, refill hold when it empties
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_hold_valid && (r_faddr < r_len)) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_lat == C_LAT) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
    // Rewind aborts any read in flight; its data is simply never captured.
    if (rewind) begin
      w_issue     = 1'b0;
      w_capture   = 1'b0;
      w_state_nxt = S_IDLE;
    end
  end

  // Fetch datapath: latency counter, hold register and fetch address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lat        <= 4'd0;
      r_hold       <= 8'd0;
      r_hold_valid <= 1'b0;
      r_faddr      <= 16'd0;
    end else if (rewind) begin
      r_lat        <= 4'd0;
      r_hold_valid <= 1'b0;
      r_faddr      <= 16'd0;
    end else begin
      if (w_capture) begin
        r_hold       <= mem_data;
        r_hold_valid <= 1'b1;
        r_faddr      <= r_faddr + 16'd1;
      end else if (w_load) begin
        r_hold_valid <= 1'b0;
      end
      if (w_issue)                r_lat <= 4'd1;
      else if (r_state == S_WAIT) r_lat <= r_lat + 4'd1;
    end
  end

  // Emitter and play controls; everything freezes while not active
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= 8'd0;
      r_bcnt    <= 4'd0;
      r_cnt     <= 16'd0;
      r_phase   <= 1'b0;
      r_cas     <= 1'b0;
      r_playing <= 1'b0;
      r_at_end  <= 1'b0;
      r_pos     <= 16'd0;
      r_len     <= 16'd0;
    end else if (rewind) begin
      r_shift   <= 8'd0;
      r_bcnt    <= 4'd0;
      r_cnt     <= 16'd0;
      r_phase   <= 1'b0;
      r_cas     <= 1'b0;
      r_playing <= 1'b0;
      r_at_end  <= 1'b0;
      r_pos     <= 16'd0;
      r_len     <= tape_len;
    end else begin
      if (w_load) begin
        r_shift <= r_hold;
        r_bcnt  <= 4'd8;
        r_cnt   <= 16'd0;
        r_phase <= 1'b0;
        r_cas   <= 1'b1;
      end else if (w_active && (r_bcnt != 4'd0)) begin
        if (!w_half_last) begin
          r_cnt <= r_cnt + 16'd1;
        end else begin
          r_cnt <= 16'd0;
          if (!r_phase) begin
            r_phase <= 1'b1;
            r_cas   <= 1'b0;
          end else begin
            r_phase <= 1'b0;
            r_shift <= r_shift >> 1;
            r_bcnt  <= r_bcnt - 4'd1;
            // Next bit of the same byte starts high immediately; after the
            // last bit the line idles low until a new byte is loaded.
            r_cas   <= (r_bcnt != 4'd1);
          end
        end
      end

      if (w_byte_done) r_pos <= w_pos_inc;

      if (w_end) begin
        r_at_end  <= 1'b1;
        r_playing <= 1'b0;
      end

      if (play_tgl) begin
        if (r_playing) begin
          r_playing <= 1'b0;
        end else begin
          r_len <= tape_len;
          if (r_at_end || (tape_len == 16'd0)) r_at_end  <= 1'b1;
          else                                 r_playing <= 1'b1;
        end
      end
    end
  end

  assign mem_addr = r_faddr;
  assign mem_rd   = w_issue;
  assign cas_out  = r_cas;
  assign playing  = r_playing;
  assign at_end   = r_at_end;
  assign tape_pos = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_cas_fsk_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cas_fsk_player
//  Description : Self-checking bench for cas_fsk_player with a bit-queue
//                reference model compared on every clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cas_fsk_player;

  localparam int HALF0  = 4;
  localparam int HALF1  = 2;
  localparam int RD_LAT = 3;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        play_tgl = 1'b0;
  logic        rewind   = 1'b0;
  logic        motor    = 1'b0;
  logic [15:0] tape_len = 16'd0;
  logic [7:0]  mem_data = 8'd0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        cas_out;
  logic        playing;
  logic        at_end;
  logic [15:0] tape_pos;

  cas_fsk_player #(.HALF0(HALF0), .HALF1(HALF1), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .play_tgl(play_tgl), .rewind(rewind),
    .motor(motor), .tape_len(tape_len), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .cas_out(cas_out), .playing(playing),
    .at_end(at_end), .tape_pos(tape_pos)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SDRAM model ----------------
  logic [7:0]  mem [0:255];
  int          pend  = 0;
  logic [7:0]  paddr = 8'd0;
  logic [15:0] rd_log [$];

  always @(negedge clk) begin
    if (pend > 0) begin
      pend--;
      if (pend == 0) mem_data = mem[paddr];
      else           mem_data = 8'($urandom);
    end else begin
      mem_data = 8'($urandom);
    end
    if (mem_rd) begin
      pend  = RD_LAT;
      paddr = mem_addr[7:0];
      rd_log.push_back(mem_addr);
    end
  end

  // ---------------- reference model ----------------
  int   m_len = 0, m_nf = 0, m_wait = 0, m_pos = 0, m_left = 0;
  logic [7:0] m_hold = 8'd0;
  bit   m_hv = 0, m_play = 0, m_end = 0, m_high = 0;
  bit   q_bits [$];
  bit   hv0, pl0;

  function automatic int half_of(input bit b);
    return b ? HALF1 : HALF0;
  endfunction

  task automatic m_clear();
    m_nf = 0; m_wait = 0; m_pos = 0; m_left = 0;
    m_hv = 0; m_play = 0; m_end = 0; m_high = 0;
    q_bits.delete();
  endtask

  task automatic m_load();
    for (int i = 0; i < 8; i++) q_bits.push_back(m_hold[i]);
    m_hv   = 0;
    m_high = 1;
    m_left = half_of(m_hold[0]);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_clear();
      m_len = 0;
    end else if (rewind) begin
      m_clear();
      m_len = int'(tape_len);
    end else begin
      hv0 = m_hv;
      pl0 = m_play;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_hold = mem[m_nf % 256];
          m_hv   = 1;
          m_nf++;
        end
      end else if (!hv0 && m_nf < m_len) begin
        m_wait = RD_LAT;
      end
      if (pl0 && motor) begin
        if (q_bits.size() == 0) begin
          if (hv0) m_load();
        end else begin
          m_left--;
          if (m_left == 0) begin
            if (m_high) begin
              m_high = 0;
              m_left = half_of(q_bits[0]);
            end else begin
              void'(q_bits.pop_front());
              if (q_bits.size() == 0) begin
                m_pos++;
                m_high = 0;
                if (m_pos == m_len) begin
                  m_end  = 1;
                  m_play = 0;
                end else if (hv0) begin
                  m_load();
                end
              end else begin
                m_high = 1;
                m_left = half_of(q_bits[0]);
              end
            end
          end
        end
      end
      if (play_tgl) begin
        if (pl0) m_play = 0;
        else begin
          m_len = int'(tape_len);
          if (m_end || tape_len == 16'd0) m_end = 1;
          else                            m_play = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("mem_rd",   32'(mem_rd),   32'(m_wait == 0 && !m_hv && m_nf < m_len && !rewind));
    chk("mem_addr", 32'(mem_addr), 32'(m_nf[15:0]));
    chk("cas_out",  32'(cas_out),  32'(q_bits.size() != 0 && m_high));
    chk("playing",  32'(playing),  32'(m_play));
    chk("at_end",   32'(at_end),   32'(m_end));
    chk("tape_pos", 32'(tape_pos), 32'(m_pos[15:0]));
  end

  // ---------------- stimulus helpers ----------------
  int runs [$];
  int emit_cycles;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_rewind(input logic [15:0] len);
    tape_len = len; rewind = 1'b1; step(); rewind = 1'b0;
  endtask

  task automatic pulse_play();
    play_tgl = 1'b1; step(); play_tgl = 1'b0;
  endtask

  task automatic run_to_end(input int limit);
    int n, cur;
    logic last;
    bit started;
    runs.delete(); emit_cycles = 0; cur = 0; started = 0; last = 1'b0; n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (at_end) break;
      if (cas_out) started = 1;
      if (started) begin
        emit_cycles++;
        if (cur == 0 || cas_out == last) cur++;
        else begin runs.push_back(cur); cur = 1; end
        last = cas_out;
      end
    end
    chk("end_reached", 32'(at_end), 32'd1);
    if (cur != 0) runs.push_back(cur);
    step();
  endtask

  int exp_basic [16] = '{2, 2, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
  int n, hi_on, len, cyc;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_rd",   32'(mem_rd),   32'd0);
    chk("rst_cas",      32'(cas_out),  32'd0);
    chk("rst_playing",  32'(playing),  32'd0);
    chk("rst_at_end",   32'(at_end),   32'd0);
    chk("rst_tape_pos", 32'(tape_pos), 32'd0);
    step(); step();
    reset = 1'b1;
    motor = 1'b1;
    step();

    // Basic playback: single byte 0x01
    mem[0] = 8'h01;
    do_rewind(16'd1);
    pulse_play();
    run_to_end(300);
    chk("basic_emit_cycles", 32'(emit_cycles), 32'd60);
    chk("basic_nruns", 32'(runs.size()), 32'd16);
    for (int i = 0; i < 16 && i < runs.size(); i++)
      chk($sformatf("basic_run%0d", i), 32'(runs[i]), 32'(exp_basic[i]));
    chk("basic_pos", 32'(tape_pos), 32'd1);
    chk("basic_playing", 32'(playing), 32'd0);

    // Prefetch: three bytes with no gaps
    mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'hAA;
    do_rewind(16'd3);
    rd_log.delete();
    pulse_play();
    run_to_end(600);
    chk("pf_emit_cycles", 32'(emit_cycles), 32'd144);
    chk("pf_nruns", 32'(runs.size()), 32'd48);
    chk("pf_nreads", 32'(rd_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < rd_log.size(); i++)
      chk($sformatf("pf_read_addr%0d", i), 32'(rd_log[i]), 32'(i));
    chk("pf_pos", 32'(tape_pos), 32'd3);

    // Pause in the middle of a high half
    mem[0] = 8'h01;
    do_rewind(16'd1);
    pulse_play();
    n = 0;
    do begin @(negedge clk); n++; end while (!cas_out && n < 50);
    chk("pause_first_high", 32'(cas_out), 32'd1);
    hi_on = 1;
    step(); motor = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("pause_hold", 32'(cas_out), 32'd1);
    end
    step(); motor = 1'b1;
    n = 0;
    while (n < 10) begin
      @(negedge clk); n++;
      if (!cas_out) break;
      if (motor) hi_on++;
    end
    chk("pause_high_total", 32'(hi_on), 32'd2);
    step();
    run_to_end(300);

    // Randomised tapes with random motor dropouts
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, 4);
      for (int a = 0; a < len; a++) mem[a] = 8'($urandom);
      do_rewind(16'(len));
      pulse_play();
      cyc = 0;
      while (!at_end && cyc < 3000) begin
        motor = ($urandom_range(0, 4) != 0);
        step();
        cyc++;
      end
      motor = 1'b1;
      chk("rand_end", 32'(at_end), 32'd1);
      chk("rand_pos", 32'(tape_pos), 32'(len));
    end

    // Rewind one clock after the read of byte 1
    mem[0] = 8'h5A; mem[1] = 8'hC3; mem[2] = 8'h0F;
    do_rewind(16'd3);
    pulse_play();
    n = 0;
    do begin @(negedge clk); n++; end while (!(mem_rd && mem_addr == 16'd1) && n < 300);
    chk("rw_saw_read1", 32'(mem_rd && mem_addr == 16'd1), 32'd1);
    step();
    rewind = 1'b1; tape_len = 16'd0;
    step();
    rewind = 1'b0;
    @(negedge clk);
    chk("rw_mem_addr", 32'(mem_addr), 32'd0);
    chk("rw_mem_rd",   32'(mem_rd),   32'd0);
    chk("rw_cas",      32'(cas_out),  32'd0);
    chk("rw_playing",  32'(playing),  32'd0);
    chk("rw_at_end",   32'(at_end),   32'd0);
    chk("rw_tape_pos", 32'(tape_pos), 32'd0);
    step();
    tape_len = 16'd3;
    rd_log.delete();
    pulse_play();
    run_to_end(600);
    chk("rw_first_addr", 32'(rd_log.size() > 0 ? rd_log[0] : 16'hFFFF), 32'd0);
    chk("rw_pos", 32'(tape_pos), 32'd3);

    // Empty tape
    do_rewind(16'd0);
    rd_log.delete();
    pulse_play();
    repeat (10) @(negedge clk);
    chk("empty_playing", 32'(playing), 32'd0);
    chk("empty_at_end",  32'(at_end),  32'd1);
    chk("empty_reads",   32'(rd_log.size()), 32'd0);
    step();

    // Rewind and play in the same clock, then async reset mid-bit
    mem[0] = 8'h00; mem[1] = 8'h81;
    tape_len = 16'd2;
    rewind = 1'b1; play_tgl = 1'b1;
    step();
    rewind = 1'b0; play_tgl = 1'b0;
    @(negedge clk);
    chk("simul_playing", 32'(playing), 32'd0);
    chk("simul_at_end",  32'(at_end),  32'd0);
    step();
    pulse_play();
    repeat (12) step();
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("areset_mem_addr", 32'(mem_addr), 32'd0);
    chk("areset_mem_rd",   32'(mem_rd),   32'd0);
    chk("areset_cas",      32'(cas_out),  32'd0);
    chk("areset_playing",  32'(playing),  32'd0);
    chk("areset_at_end",   32'(at_end),   32'd0);
    chk("areset_tape_pos", 32'(tape_pos), 32'd0);
    step(); step();
    reset = 1'b1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
